fifo_uart_tx: RTL and testbench
===============================

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, clk cycles per serial bit (100 MHz / 115200 baud); legal range >= 2.
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port fifo_data  input  8  byte from upstream FIFO dataOut; valid the cycle after fifo_rd.
REQ-005 SHALL have port fifo_empty  input  1  upstream FIFO EMPTY flag.
REQ-006 SHALL have port fifo_rd  output  1  one-cycle read strobe to upstream FIFO Rd.
REQ-007 SHALL have port TxD  output  1  serial line, idle high, registered.
REQ-008 SHALL have port busy  output  1  high whenever state != IDLE.
REQ-009 SHALL have port tx_done  output  1  one-cycle pulse on the last cycle of the stop bit.

Function
REQ-010 SHALL implement Moore FSM states IDLE, READ, FETCH, START, DATA, PARITY, STOP.
REQ-011 IDLE: TxD=1; SHALL go to READ when fifo_empty sampled 0, else stay in IDLE.
REQ-012 READ: fifo_rd=1 for exactly this one cycle; next state FETCH unconditionally.
REQ-013 FETCH: SHALL latch fifo_data into an 8-bit shift register; next state START.
REQ-014 START: TxD=0 for CLKS_PER_BIT cycles, then DATA.
REQ-015 DATA: SHALL send 8 bits LSB first, each held CLKS_PER_BIT cycles; 3-bit bit index 0..7; after bit 7 go to PARITY (if enabled) else STOP.
REQ-016 STOP: TxD=1 for CLKS_PER_BIT cycles; tx_done=1 on final cycle; next state IDLE.
REQ-017 Baud counter width SHALL be $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1, clears on every bit boundary and on state entry; no drift across a frame.
REQ-018 Frame length SHALL be exactly 10*CLKS_PER_BIT cycles (11*CLKS_PER_BIT with parity).
REQ-019 fifo_empty SHALL be ignored in every state except IDLE; fifo_rd SHALL never assert outside READ (no read on empty FIFO, no double read).
REQ-020 Back-to-back: with fifo_empty held 0, gap between end of STOP and next START SHALL be exactly 3 cycles of TxD=1 (IDLE, READ, FETCH).
REQ-021 Latency: fifo_empty sampled 0 in IDLE at edge k -> fifo_rd high cycle k+1 -> TxD falls at cycle k+3.
REQ-022 Shift register contents SHALL not change between FETCH and the next FETCH.

Reset
REQ-023 On reset sampled high: state=IDLE, TxD=1, fifo_rd=0, busy=0, tx_done=0, counters=0, shift register=0, effective at that edge.
REQ-024 Reset mid-frame SHALL abort the frame (TxD=1 from the next cycle), discard the byte, issue no fifo_rd while reset is high.
REQ-025 After reset deasserts, transmission SHALL resume only via IDLE->READ.

Configuration
REQ-026 Macro FIFO_UART_TX_PARITY_EN defined: PARITY state SHALL follow DATA and send even parity (XOR of 8 data bits) for CLKS_PER_BIT cycles.
REQ-027 Macro undefined: PARITY state and parity logic SHALL be absent; DATA goes directly to STOP.

Verification (CLKS_PER_BIT=4)
REQ-028 Reset, then fifo_empty=1 for 200 cycles -> TxD=1, fifo_rd=0, busy=0 throughout.
REQ-029 Single byte 0xA5 -> one fifo_rd pulse; TxD bits 0,1,0,1,0,0,1,0,1,1 each 4 cycles; tx_done one pulse on cycle 40 of the frame.
REQ-030 Bytes 0x00 then 0xFF, fifo_empty held 0 -> two correct frames separated by exactly 3 high cycles; exactly 2 fifo_rd pulses.
REQ-031 Reset asserted during data bit 3 of 0x3C -> TxD=1, busy=0 next cycle; no fifo_rd during reset; next frame starts cleanly after release.
REQ-032 With FIFO_UART_TX_PARITY_EN, byte 0x07 -> parity bit 1, frame 44 cycles; byte 0x03 -> parity bit 0; without the macro -> frame 40 cycles, no parity bit.
REQ-033 fifo_empty toggled every cycle during a frame -> no extra fifo_rd; frame unchanged.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pulls bytes from an upstream FIFO and sends them as 8N1 UART frames.
// The frame is start, 8 data bits LSB first, then stop.
// Optional feature: define FIFO_UART_TX_PARITY_EN to insert an even-parity bit before stop.
// All outputs are registered and decoded from the next state, so they line up with the state register.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] fifo_data,
  input  logic       fifo_empty,
  output logic       fifo_rd,
  output logic       TxD,
  output logic       busy,
  output logic       tx_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    FETCH,
    START,
    DATA,
`ifdef FIFO_UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, txd_d;
  logic          fifo_rd_q, fifo_rd_d;
  logic          busy_q, busy_d;
  logic          tx_done_q, tx_done_d;
  logic          bit_end;

  // Next-state, counter and output decode; the byte is held unshifted and indexed by bit_q.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    bit_end   = (cnt_q == CNT_MAX);

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!fifo_empty) state_d = READ;
      end
      READ: begin
        state_d = FETCH;
      end
      FETCH: begin
        shift_d = fifo_data;
        cnt_d   = '0;
        state_d = START;
      end
      START: begin
        if (bit_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        bit_d   = '0;
        state_d = IDLE;
      end
    endcase

    fifo_rd_d = (state_d == READ);
    busy_d    = (state_d != IDLE);
    tx_done_d = (state_d == STOP) && (cnt_d == CNT_MAX);

    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[bit_d];
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY:  txd_d = ^shift_d;
`endif
      default: txd_d = 1'b1;
    endcase
  end

  // State and registered outputs; reset aborts any frame and drops the held byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      txd_q     <= 1'b1;
      fifo_rd_q <= 1'b0;
      busy_q    <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      txd_q     <= txd_d;
      fifo_rd_q <= fifo_rd_d;
      busy_q    <= busy_d;
      tx_done_q <= tx_done_d;
    end
  end

  assign TxD     = txd_q;
  assign fifo_rd = fifo_rd_q;
  assign busy    = busy_q;
  assign tx_done = tx_done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed bench for fifo_uart_tx at CLKS_PER_BIT=4.
// It follows the FIFO_UART_TX_PARITY_EN build setting for the expected frame length.
module tb_fifo_uart_tx;

  localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int FRAME = 11 * CPB;
  localparam bit PAR   = 1'b1;
`else
  localparam int FRAME = 10 * CPB;
  localparam bit PAR   = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic [7:0] fifo_data;
  logic       fifo_empty;
  logic       fifo_rd;
  logic       TxD;
  logic       busy;
  logic       tx_done;

  int checks;
  int failures;
  int rd_count;
  int rd_base;
  logic [7:0] fifo_q[$];

  fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .reset      (reset),
    .fifo_data  (fifo_data),
    .fifo_empty (fifo_empty),
    .fifo_rd    (fifo_rd),
    .TxD        (TxD),
    .busy       (busy),
    .tx_done    (tx_done)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Upstream FIFO model: the popped byte is valid only in the cycle after the read strobe
  always @(posedge clk) begin
    if (fifo_rd && fifo_q.size() > 0) fifo_data <= fifo_q.pop_front();
    else fifo_data <= 8'hC3;
  end

  // Count every read strobe, sampled mid-cycle
  always @(negedge clk) begin
    if (fifo_rd) rd_count++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rst, input logic empty);
    reset      = rst;
    fifo_empty = empty;
    tick();
  endtask

  // Walks one whole frame starting with its first START cycle, checking every cycle
  task automatic checkFrame(input logic [7:0] b, input bit toggle, input string tag);
    int slot;
    logic exp_txd;
    for (int c = 0; c < FRAME; c++) begin
      if (toggle) fifo_empty = ~fifo_empty;
      tick();
      slot = c / CPB;
      if (slot == 0) exp_txd = 1'b0;
      else if (slot <= 8) exp_txd = b[slot-1];
      else if (slot == 9 && PAR) exp_txd = ^b;
      else exp_txd = 1'b1;
      checkOutput({tag, "_txd"}, 32'(TxD), 32'(exp_txd));
      checkOutput({tag, "_done"}, 32'(tx_done), 32'(c == FRAME - 1));
      checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
      checkOutput({tag, "_rd"}, 32'(fifo_rd), 32'd0);
    end
  endtask

  // Single byte from an idle line: strobe, fetch cycle, then frame
  task automatic sendByte(input logic [7:0] b, input bit toggle, input string tag);
    fifo_q.push_back(b);
    applyStimulus(1'b0, 1'b0);
    checkOutput({tag, "_lat_rd"}, 32'(fifo_rd), 32'd1);
    checkOutput({tag, "_lat_txd"}, 32'(TxD), 32'd1);
    applyStimulus(1'b0, 1'b1);
    checkOutput({tag, "_fetch_rd"}, 32'(fifo_rd), 32'd0);
    checkOutput({tag, "_fetch_txd"}, 32'(TxD), 32'd1);
    checkFrame(b, toggle, tag);
    fifo_empty = 1'b1;
    tick();
    checkOutput({tag, "_end_txd"}, 32'(TxD), 32'd1);
    checkOutput({tag, "_end_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rd_count   = 0;
    reset      = 1'b1;
    fifo_empty = 1'b1;
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1);
    checkOutput("rst_txd", 32'(TxD), 32'd1);
    checkOutput("rst_rd", 32'(fifo_rd), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(tx_done), 32'd0);

    $display("[TB] idle with empty FIFO");
    for (int i = 0; i < 200; i++) begin
      applyStimulus(1'b0, 1'b1);
      checkOutput("idle_txd", 32'(TxD), 32'd1);
      checkOutput("idle_rd", 32'(fifo_rd), 32'd0);
      checkOutput("idle_busy", 32'(busy), 32'd0);
    end

    $display("[TB] single byte 0xA5");
    rd_base = rd_count;
    sendByte(8'hA5, 1'b0, "a5");
    checkOutput("a5_rd_count", 32'(rd_count - rd_base), 32'd1);

    $display("[TB] back-to-back 0x00 then 0xFF");
    rd_base = rd_count;
    fifo_q.push_back(8'h00);
    fifo_q.push_back(8'hFF);
    applyStimulus(1'b0, 1'b0);
    checkOutput("b2b_rd1", 32'(fifo_rd), 32'd1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("b2b_fetch1", 32'(TxD), 32'd1);
    checkFrame(8'h00, 1'b0, "b2b_00");
    applyStimulus(1'b0, 1'b0);
    checkOutput("gap_idle_txd", 32'(TxD), 32'd1);
    checkOutput("gap_idle_busy", 32'(busy), 32'd0);
    checkOutput("gap_idle_rd", 32'(fifo_rd), 32'd0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("gap_read_txd", 32'(TxD), 32'd1);
    checkOutput("gap_read_rd", 32'(fifo_rd), 32'd1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("gap_fetch_txd", 32'(TxD), 32'd1);
    checkOutput("gap_fetch_rd", 32'(fifo_rd), 32'd0);
    checkFrame(8'hFF, 1'b0, "b2b_ff");
    applyStimulus(1'b0, 1'b1);
    checkOutput("b2b_end_busy", 32'(busy), 32'd0);
    checkOutput("b2b_rd_count", 32'(rd_count - rd_base), 32'd2);

    $display("[TB] reset during data bit 3 of 0x3C");
    rd_base = rd_count;
    fifo_q.push_back(8'h3C);
    applyStimulus(1'b0, 1'b0);
    checkOutput("rst3c_rd", 32'(fifo_rd), 32'd1);
    applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < 18; i++) tick();
    checkOutput("rst3c_mid_busy", 32'(busy), 32'd1);
    checkOutput("rst3c_mid_txd", 32'(TxD), 32'd1);
    applyStimulus(1'b1, 1'b0);
    checkOutput("rst3c_txd", 32'(TxD), 32'd1);
    checkOutput("rst3c_busy", 32'(busy), 32'd0);
    checkOutput("rst3c_done", 32'(tx_done), 32'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput("rst3c_hold_rd", 32'(fifo_rd), 32'd0);
      checkOutput("rst3c_hold_txd", 32'(TxD), 32'd1);
    end
    applyStimulus(1'b0, 1'b1);
    checkOutput("rst3c_rel_busy", 32'(busy), 32'd0);
    checkOutput("rst3c_rd_count", 32'(rd_count - rd_base), 32'd1);
    sendByte(8'h3C, 1'b0, "after_rst");

    $display("[TB] parity bytes 0x07 and 0x03");
    sendByte(8'h07, 1'b0, "p07");
    sendByte(8'h03, 1'b0, "p03");

    $display("[TB] fifo_empty toggling during a frame");
    rd_base = rd_count;
    sendByte(8'h96, 1'b1, "tog");
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1);
    checkOutput("tog_rd_count", 32'(rd_count - rd_base), 32'd1);
    checkOutput("tog_idle_txd", 32'(TxD), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
